// File: rtl/psum_acc_mem.sv
// ---------------------------------------------------------------------------
// psum_acc_mem
//   Partial-sum memory with an in-place accumulate mode. Each op passes
//   through two pipeline stages:
//     stage 1 (issue edge)  : capture op/A/D and read the addressed word
//     stage 2 (commit edge) : write, return read data, or accumulate and
//                             write back (optional ReLU, per-lane saturation)
//   When the op in stage 2 writes the address that stage 1 is reading, the
//   value being committed is forwarded to stage 1. This keeps back-to-back
//   accumulates to one address in program order at full throughput.
//
// Ports
//   clk      : clock, all state updates on the rising edge
//   reset    : synchronous, active-high; clears the pipeline, not the memory
//   CEN      : chip enable, active low (1 = idle cycle)
//   op       : 00 read, 01 write, 10 accumulate, 11 accumulate + ReLU
//   A        : word address
//   D        : write data / accumulate addend, col lanes of psum_bw bits
//   Q        : read data or committed accumulate result
//   q_valid  : one-cycle pulse, Q holds a read or accumulate result
//   ovf      : per-lane saturation flags of the reported accumulate
//   busy     : stage-2 valid bit
// ---------------------------------------------------------------------------
module psum_acc_mem #(
  parameter int psum_bw    = 16,
  parameter int col        = 8,
  parameter int addr_width = 11,
  parameter int depth      = 1 << addr_width
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   CEN,
  input  logic [1:0]             op,
  input  logic [addr_width-1:0]  A,
  input  logic [psum_bw*col-1:0] D,
  output logic [psum_bw*col-1:0] Q,
  output logic                   q_valid,
  output logic [col-1:0]         ovf,
  output logic                   busy
);

  localparam int W = psum_bw * col;
  localparam logic [addr_width:0] DEPTH_W  = (addr_width + 1)'(depth);
  localparam logic [psum_bw-1:0]  LANE_MAX = {1'b0, {(psum_bw - 1){1'b1}}};
  localparam logic [psum_bw-1:0]  LANE_MIN = {1'b1, {(psum_bw - 1){1'b0}}};

  typedef enum logic [1:0] {
    OP_READ     = 2'b00,
    OP_WRITE    = 2'b01,
    OP_ACC      = 2'b10,
    OP_ACC_RELU = 2'b11
  } op_e;

  // storage
  logic [W-1:0] mem [0:depth-1];
  logic [W-1:0] mem_rd_q;

  // stage 1 registers
  logic                  s1_valid_q, s1_valid_d;
  op_e                   s1_op_q,    s1_op_d;
  logic [addr_width-1:0] s1_a_q,     s1_a_d;
  logic [W-1:0]          s1_d_q,     s1_d_d;
  logic                  s1_inr_q,   s1_inr_d;
  logic                  fwd_q,      fwd_d;
  logic [W-1:0]          fwd_data_q, fwd_data_d;

  // stage 2 registers
  logic                  s2_valid_q, s2_valid_d;
  logic [W-1:0]          q_q,        q_d;
  logic                  q_valid_q,  q_valid_d;
  logic [col-1:0]        ovf_q,      ovf_d;

  // stage 2 datapath
  logic [W-1:0]          raw;
  logic [W-1:0]          acc_sum;
  logic [col-1:0]        acc_ovf;
  logic                  relu_en;
  logic [W-1:0]          commit_data;
  logic                  commit_we;

  // -------------------------------------------------------------------------
  // Stage 1 capture
  // -------------------------------------------------------------------------
  always_comb begin
    s1_valid_d = ~CEN;
    s1_op_d    = op_e'(op);
    s1_a_d     = A;
    s1_d_d     = D;
    s1_inr_d   = ({1'b0, A} < DEPTH_W);
    // The RAM read at this edge returns the pre-write word when stage 2
    // commits to the same address, so the committed value is captured too.
    fwd_d      = commit_we && !CEN && (A == s1_a_q);
    fwd_data_d = commit_data;
  end

  // Registered-read RAM; the write port is used by stage 2 only.
  always_ff @(posedge clk) begin
    if (!CEN) begin
      mem_rd_q <= mem[A];
    end
    if (commit_we) begin
      mem[s1_a_q] <= commit_data;
    end
  end

  // -------------------------------------------------------------------------
  // Stage 2 datapath
  // -------------------------------------------------------------------------
  always_comb begin
    raw = '0;
    if (s1_inr_q) begin
      raw = fwd_q ? fwd_data_q : mem_rd_q;
    end
  end

  assign relu_en = (s1_op_q == OP_ACC_RELU);

  // Lanes are independent: add in psum_bw+1 bits, clamp, then ReLU.
  for (genvar gi = 0; gi < col; gi++) begin : g_lane
    logic [psum_bw-1:0] raw_l;
    logic [psum_bw-1:0] add_l;
    logic [psum_bw:0]   sum_l;
    logic [psum_bw-1:0] sat_l;
    logic               ovf_l;

    assign raw_l = raw[psum_bw*gi +: psum_bw];
    assign add_l = s1_d_q[psum_bw*gi +: psum_bw];
    assign sum_l = {raw_l[psum_bw-1], raw_l} + {add_l[psum_bw-1], add_l};

    always_comb begin
      sat_l = sum_l[psum_bw-1:0];
      ovf_l = 1'b0;
      // The two top bits differ only when the true sum left the lane range.
      if (sum_l[psum_bw] != sum_l[psum_bw-1]) begin
        ovf_l = 1'b1;
        sat_l = sum_l[psum_bw] ? LANE_MIN : LANE_MAX;
      end
      if (relu_en && sat_l[psum_bw-1]) begin
        sat_l = '0;
      end
    end

    assign acc_sum[psum_bw*gi +: psum_bw] = sat_l;
    assign acc_ovf[gi]                    = ovf_l;
  end

  always_comb begin
    commit_data = (s1_op_q == OP_WRITE) ? s1_d_q : acc_sum;
    // Reset suppresses the write of the op caught at that edge.
    commit_we   = s1_valid_q && s1_inr_q && (s1_op_q != OP_READ) && !reset;
  end

  always_comb begin
    s2_valid_d = s1_valid_q;
    q_d        = q_q;
    q_valid_d  = 1'b0;
    ovf_d      = '0;
    if (s1_valid_q) begin
      unique case (s1_op_q)
        OP_READ: begin
          q_d       = raw;
          q_valid_d = 1'b1;
        end
        OP_ACC, OP_ACC_RELU: begin
          q_d       = acc_sum;
          q_valid_d = 1'b1;
          ovf_d     = acc_ovf;
        end
        default: ;  // write: Q holds its previous value
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      fwd_q      <= 1'b0;
      s2_valid_q <= 1'b0;
      q_q        <= '0;
      q_valid_q  <= 1'b0;
      ovf_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      fwd_q      <= fwd_d;
      s2_valid_q <= s2_valid_d;
      q_q        <= q_d;
      q_valid_q  <= q_valid_d;
      ovf_q      <= ovf_d;
    end
  end

  // Payload registers are qualified by the valid bits and need no reset.
  always_ff @(posedge clk) begin
    s1_op_q    <= s1_op_d;
    s1_a_q     <= s1_a_d;
    s1_d_q     <= s1_d_d;
    s1_inr_q   <= s1_inr_d;
    fwd_data_q <= fwd_data_d;
  end

  assign Q       = q_q;
  assign q_valid = q_valid_q;
  assign ovf     = ovf_q;
  assign busy    = s2_valid_q;

endmodule

// File: tb/tb_psum_acc_mem.sv
// ---------------------------------------------------------------------------
// tb_psum_acc_mem
//   Directed-vector bench for psum_acc_mem. Depth is reduced to 1024 so that
//   addresses 1024..2047 exercise the out-of-range behaviour.
// ---------------------------------------------------------------------------
module tb_psum_acc_mem;

  localparam int PBW   = 16;
  localparam int COL   = 8;
  localparam int AW    = 11;
  localparam int DEPTH = 1024;
  localparam int W     = PBW * COL;

  localparam logic [1:0] RD   = 2'b00;
  localparam logic [1:0] WR   = 2'b01;
  localparam logic [1:0] ACC  = 2'b10;
  localparam logic [1:0] ACCR = 2'b11;

  logic           clk = 1'b0;
  logic           reset;
  logic           CEN;
  logic [1:0]     op;
  logic [AW-1:0]  A;
  logic [W-1:0]   D;
  logic [W-1:0]   Q;
  logic           q_valid;
  logic [COL-1:0] ovf;
  logic           busy;

  int n_vec  = 0;
  int n_miss = 0;

  psum_acc_mem #(
    .psum_bw   (PBW),
    .col       (COL),
    .addr_width(AW),
    .depth     (DEPTH)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .CEN    (CEN),
    .op     (op),
    .A      (A),
    .D      (D),
    .Q      (Q),
    .q_valid(q_valid),
    .ovf    (ovf),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Drive one cycle of inputs, clock once, then settle past the edge.
  task automatic step(input logic cen, input logic [1:0] o, input int a, input logic [W-1:0] d);
    CEN = cen;
    op  = o;
    A   = AW'(a);
    D   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b1, RD, 0, '0);
  endtask

  function automatic logic [W-1:0] all_lanes(input logic [PBW-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < COL; i++) r[PBW*i +: PBW] = v;
    return r;
  endfunction

  function automatic logic [W-1:0] two_lanes(input logic [PBW-1:0] l0, input logic [PBW-1:0] l1);
    logic [W-1:0] r;
    r = '0;
    r[PBW-1:0]     = l0;
    r[2*PBW-1:PBW] = l1;
    return r;
  endfunction

  function automatic logic [W-1:0] ramp_lanes();
    logic [W-1:0] r;
    for (int i = 0; i < COL; i++) r[PBW*i +: PBW] = PBW'(i + 1);
    return r;
  endfunction

  initial begin
    logic [W-1:0] rnd_d;
    reset = 1'b1;
    CEN   = 1'b1;
    op    = RD;
    A     = '0;
    D     = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst Q", Q, '0);
    chk("rst q_valid", W'(q_valid), '0);
    chk("rst ovf", W'(ovf), '0);
    chk("rst busy", W'(busy), '0);
    reset = 1'b0;

    // 1: write then read back
    step(1'b0, WR, 5, ramp_lanes());
    step(1'b0, RD, 5, '0);
    chk("t1 write no pulse", W'(q_valid), '0);
    idle();
    chk("t1 read Q", Q, ramp_lanes());
    chk("t1 read q_valid", W'(q_valid), 1);
    chk("t1 read ovf", W'(ovf), '0);
    idle();
    chk("t1 single pulse", W'(q_valid), '0);

    // 2: back-to-back accumulates rely on forwarding
    step(1'b0, WR, 3, all_lanes(16'd10));
    step(1'b0, ACC, 3, all_lanes(16'd1));
    step(1'b0, ACC, 3, all_lanes(16'd1));
    chk("t2 acc1 Q", Q, all_lanes(16'd11));
    step(1'b0, ACC, 3, all_lanes(16'd1));
    chk("t2 acc2 Q", Q, all_lanes(16'd12));
    step(1'b0, ACC, 3, all_lanes(16'd1));
    chk("t2 acc3 Q", Q, all_lanes(16'd13));
    step(1'b0, RD, 3, '0);
    chk("t2 acc4 Q", Q, all_lanes(16'd14));
    chk("t2 acc4 q_valid", W'(q_valid), 1);
    idle();
    chk("t2 read Q", Q, all_lanes(16'd14));
    chk("t2 read q_valid", W'(q_valid), 1);

    // 3: saturation both directions (32760+100, -32760-100)
    step(1'b0, WR, 0, two_lanes(16'h7FF8, 16'h8008));
    step(1'b0, ACC, 0, two_lanes(16'h0064, 16'hFF9C));
    idle();
    chk("t3 sat Q", Q, two_lanes(16'h7FFF, 16'h8000));
    chk("t3 sat ovf", W'(ovf), 8'h03);
    idle();
    chk("t3 ovf clears", W'(ovf), '0);

    // 4: ReLU clamps -3 to 0; plain accumulate keeps -2
    step(1'b0, WR, 7, all_lanes(16'hFFFB));
    step(1'b0, WR, 8, all_lanes(16'd4));
    step(1'b0, ACCR, 7, all_lanes(16'd2));
    step(1'b0, ACC, 8, all_lanes(16'hFFFA));
    chk("t4 relu Q", Q, '0);
    chk("t4 relu ovf", W'(ovf), '0);
    chk("t4 relu q_valid", W'(q_valid), 1);
    step(1'b0, RD, 7, '0);
    chk("t4 acc Q", Q, all_lanes(16'hFFFE));
    idle();
    chk("t4 mem7 Q", Q, '0);

    // 5: reset kills an in-flight accumulate
    step(1'b0, WR, 9, all_lanes(16'd1));
    idle();
    step(1'b0, ACC, 9, all_lanes(16'd1));
    reset = 1'b1;
    idle();
    reset = 1'b0;
    chk("t5 q_valid after rst", W'(q_valid), '0);
    chk("t5 busy after rst", W'(busy), '0);
    idle();
    chk("t5 q_valid later", W'(q_valid), '0);
    step(1'b0, RD, 9, '0);
    idle();
    chk("t5 mem9 Q", Q, all_lanes(16'd1));

    // 6: idle cycles with random op/A/D on the bus
    idle();
    idle();
    step(1'b0, WR, 20, all_lanes(16'h0A5A));
    chk("t6 busy before commit", W'(busy), '0);
    for (int i = 0; i < 3; i++) begin
      rnd_d = {$urandom, $urandom, $urandom, $urandom};
      step(1'b1, 2'($urandom_range(0, 3)), ($urandom_range(0, 1) == 0) ? 5 : 20, rnd_d);
      chk($sformatf("t6 idle%0d q_valid", i), W'(q_valid), '0);
      chk($sformatf("t6 idle%0d busy", i), W'(busy), (i == 0) ? 1 : 0);
    end
    step(1'b0, RD, 20, '0);
    step(1'b0, RD, 5, '0);
    chk("t6 mem20 Q", Q, all_lanes(16'h0A5A));
    idle();
    chk("t6 mem5 Q", Q, ramp_lanes());

    // 7: out-of-range address
    step(1'b0, WR, 476, all_lanes(16'h1234));
    step(1'b0, WR, 1500, all_lanes(16'hBEEF));
    step(1'b0, RD, 1500, '0);
    step(1'b0, ACC, 1500, all_lanes(16'd3));
    chk("t7 oor read Q", Q, '0);
    chk("t7 oor read q_valid", W'(q_valid), 1);
    step(1'b0, RD, 476, '0);
    chk("t7 oor acc q_valid", W'(q_valid), 1);
    idle();
    chk("t7 no alias Q", Q, all_lanes(16'h1234));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/psum_acc_mem.md
Name: psum_acc_mem

Overview:
Parametrised partial-sum memory that replaces the plain output psum SRAM model. It adds an in-place accumulate mode: a read-modify-write of `col` signed lanes, with optional ReLU and per-lane saturation. It sits between the corelet OFIFO/SFU and the psum storage, and takes the same CEN-style access interface. A uniform two-stage pipeline with commit-stage forwarding makes back-to-back accumulates to the same address hazard-free.

Parameters:
psum_bw, 16, bits per lane (signed two's complement)
col, 8, lanes per word; word width = psum_bw*col
addr_width, 11, address bits
depth, 1<<addr_width, number of words (must be <= 2**addr_width)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
CEN  input  1  chip enable, active-low; 1 = idle cycle
op  input  2  00 read, 01 write, 10 accumulate, 11 accumulate+ReLU
A  input  addr_width  word address
D  input  psum_bw*col  write data / accumulate addend, lane i = D[psum_bw*(i+1)-1 : psum_bw*i]
Q  output  psum_bw*col  read data, or the value just committed by an accumulate
q_valid  output  1  one-cycle pulse: Q holds the result of a read or accumulate
ovf  output  col  per-lane saturation flags for the accumulate reported with q_valid; 0 otherwise
busy  output  1  1 while stage 2 holds a valid op (informational; the block never stalls)

Behaviour:
- Reset (sync, active-high): stage-1/2 valid bits, Q, q_valid, ovf and busy all go to 0. Memory contents are NOT cleared.
- Reset mid-pipeline: any op in stage 1 or stage 2 is dropped, and no memory write occurs at that edge.
- Stage 1, edge k, when CEN=0:
  - register op, A, D, valid=1;
  - read raw = mem[A].
  - If stage 2 commits a write to the same A at this same edge, raw takes the committed value (forwarding), not the stale mem value.
- CEN=1: stage-1 valid=0 and no memory access.
- Stage 2, edge k+1, when stage-2 valid:
  - write: mem[A] <= D; Q unchanged; q_valid=0.
  - read: Q <= raw; q_valid=1; ovf=0.
  - accumulate: per lane, s = sat(raw_i + D_i), where sat clamps to [-2^(psum_bw-1), 2^(psum_bw-1)-1] and ovf_i=1 if clamped.
    - ReLU mode (op=11) then sets s=0 when s<0; ovf still reflects saturation before ReLU.
    - mem[A] <= s; Q <= s; q_valid=1.
- Latency and throughput:
  - read data / accumulate result appear on Q two edges after issue;
  - memory write is visible to a read issued at the commit edge or later;
  - full throughput, one op per cycle with any address sequence.
- There is only one write port, used at stage 2, so no same-edge write conflicts exist.
- Ordering: program order holds for every address. The forwarding path covers distance-1 hazards; distance >= 2 is served by memory.
- When stage 2 is not valid or holds a write: q_valid=0 and ovf=0.
- busy equals the stage-2 valid bit.
- Out-of-range A (>= depth): a read returns 0, and writes/accumulates are discarded. q_valid still pulses for read and accumulate.
- Arithmetic: lanes are fully independent, with no carry between lanes; sign extension is internal to psum_bw+1 bits.

Test Plan:
1. Write A=5 D=lanes{1..8}, then read A=5 -> two edges after the read, Q=lanes{1..8}, q_valid pulses once, ovf=0.
2. Write A=3 all lanes 10, then four back-to-back accumulates A=3 D=all 1 -> Q sequence 11, 12, 13, 14 on consecutive cycles (forwarding); then read A=3 returns 14.
3. Write A=0 lane0=32760, lane1=-32760, then accumulate D lane0=100, lane1=-100 -> Q lane0=32767, lane1=-32768, ovf=8'b00000011.
4. Write A=7 all lanes -5, then op=11 with D=all 2 -> Q all 0, ovf=0, and mem[7] reads 0; op=10 on A=8 (holding 4) with D=-6 -> Q=-2.
5. Issue an accumulate on A=9 (holding 1, D=1) and assert reset on the following edge -> q_valid stays 0, busy=0, and a later read of A=9 returns 1.
6. CEN=1 for 3 cycles between ops with random op/A/D -> memory unchanged, q_valid=0, busy falls 1 cycle after the last valid op commits.
